// File: rtl/sd_resp_rx_pkg.sv
// Shared definitions for the SD response path: FSM encoding, R1 bit map,
// response lengths and the default Ncr timeout.
package sd_resp_rx_pkg;

  typedef enum logic [1:0] {
    ST_IDLE       = 2'd0,
    ST_WAIT_START = 2'd1,
    ST_SHIFT      = 2'd2,
    ST_FINISH     = 2'd3
  } state_e;

  // R1 status bit positions
  localparam int R1_IDLE          = 0;
  localparam int R1_ERASE_RESET   = 1;
  localparam int R1_ILLEGAL_CMD   = 2;
  localparam int R1_CRC_ERR       = 3;
  localparam int R1_ERASE_SEQ_ERR = 4;
  localparam int R1_ADDR_ERR      = 5;
  localparam int R1_PARAM_ERR     = 6;

  localparam int R1_BITS     = 8;
  localparam int R7_BITS     = 40;
  localparam int NCR_TIMEOUT = 80;

  function automatic logic r1_has_error(input logic [7:0] r1);
    return |r1[R1_PARAM_ERR:R1_ERASE_RESET];
  endfunction

endpackage

// File: rtl/sd_bit_timer.sv
// Bit-clock counter with load, enable and an expired flag that is high while
// the current sample is the LIMIT-th one. Saturates at LIMIT, never wraps.
module sd_bit_timer #(
  parameter int LIMIT = 80,
  localparam int W    = $clog2(LIMIT + 1)
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  input  logic en,
  output logic expired
);

  logic [W-1:0] count;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of process ordering.
  always_ff @(posedge clk) begin
    if (rst || load) begin
      count <= '0;
    end else if (en && (count != W'(LIMIT))) begin
      count <= count + 1'b1;
    end
  end

  assign expired = (count == W'(LIMIT - 1));

endmodule

// File: rtl/sd_resp_rx.sv
// SD serial response receiver: waits for the start bit, shifts in an R1 or
// R3/R7 response MSB-first and presents decoded fields with a done strobe.
module sd_resp_rx
  import sd_resp_rx_pkg::*;
#(
  parameter int TIMEOUT_BITS = NCR_TIMEOUT,
  parameter int LONG_BITS    = R7_BITS
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        long_resp,
  input  logic        sdi,
  output logic        busy,
  output logic        done,
  output logic        timeout,
  output logic [7:0]  r1,
  output logic [31:0] payload,
  output logic        card_idle,
  output logic        resp_err
);

  state_e               state, state_next;
  logic [5:0]           bitcnt;
  logic [LONG_BITS-1:0] shreg;
  logic [LONG_BITS-1:0] shreg_next;
  logic                 long_q;
  logic                 last_bit;
  logic                 timer_load, timer_en, timer_expired;
  logic                 shift_en, capture, fire_timeout;
  logic [7:0]           r1_next;

  sd_bit_timer #(.LIMIT(TIMEOUT_BITS)) u_ncr_timer (
    .clk     (clk),
    .rst     (rst),
    .load    (timer_load),
    .en      (timer_en),
    .expired (timer_expired)
  );

  assign shreg_next = {shreg[LONG_BITS-2:0], sdi};
  assign last_bit   = (bitcnt == (long_q ? 6'(LONG_BITS - 1) : 6'(R1_BITS - 1)));
  assign r1_next    = long_q ? shreg_next[LONG_BITS-1 -: 8] : shreg_next[7:0];
  assign busy       = (state == ST_WAIT_START) || (state == ST_SHIFT);

  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_next;
  end

  // NOTE: every combinational output gets a default first so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    state_next   = state;
    timer_load   = 1'b0;
    timer_en     = 1'b0;
    shift_en     = 1'b0;
    capture      = 1'b0;
    fire_timeout = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (start) begin
          timer_load = 1'b1;
          state_next = ST_WAIT_START;
        end
      end
      ST_WAIT_START: begin
        if (!sdi) begin
          shift_en   = 1'b1;
          state_next = ST_SHIFT;
        end else if (timer_expired) begin
          fire_timeout = 1'b1;
          state_next   = ST_IDLE;
        end else begin
          timer_en = 1'b1;
        end
      end
      ST_SHIFT: begin
        shift_en = 1'b1;
        if (last_bit) begin
          capture    = 1'b1;
          state_next = ST_FINISH;
        end
      end
      ST_FINISH: state_next = ST_IDLE;
      default:   state_next = ST_IDLE;
    endcase
  end

  // Outputs load on the edge that samples the last bit, so they are valid
  // in the same cycle as the done strobe.
  always_ff @(posedge clk) begin
    if (rst) begin
      bitcnt    <= '0;
      shreg     <= '0;
      long_q    <= 1'b0;
      done      <= 1'b0;
      timeout   <= 1'b0;
      r1        <= '0;
      payload   <= '0;
      card_idle <= 1'b0;
      resp_err  <= 1'b0;
    end else begin
      done    <= capture;
      timeout <= fire_timeout;
      if (state == ST_IDLE && start) begin
        long_q <= long_resp;
        bitcnt <= '0;
        shreg  <= '0;
      end
      if (shift_en) begin
        shreg  <= shreg_next;
        bitcnt <= bitcnt + 1'b1;
      end
      if (capture) begin
        r1        <= r1_next;
        payload   <= long_q ? shreg_next[31:0] : 32'd0;
        card_idle <= r1_next[R1_IDLE];
        resp_err  <= r1_has_error(r1_next);
      end
    end
  end

endmodule
